// File: rtl/alu1_seq_ctrl_if.sv
// alu1_seq_ctrl_if
//   Groups the issue handshake, flush/divider controls, writeback and wakeup
//   signals of the ALU1 multiply/divide sequencer.
//   modport master : environment side. It drives the issue, flush, div_done
//                    and result_ack inputs and observes the controller outputs.
//   modport slave  : controller side (alu1_seq_ctrl).
interface alu1_seq_ctrl_if;
    logic       issue_vld;
    logic       issue_is_div;
    logic [5:0] issue_PR;
    logic       issue_rdy;
    logic       flush;
    logic       div_done;
    logic       result_ack;
    logic       ALU1_start;
    logic       ALU1_op_div;
    logic       ALU1_kill;
    logic       ALU1_result_vld;
    logic [5:0] ALU1_result_PR;
    logic       ALU1_wakeup_vld;
    logic [5:0] ALU1_wakeup_PR;

    modport master (
        output issue_vld, issue_is_div, issue_PR, flush, div_done, result_ack,
        input  issue_rdy, ALU1_start, ALU1_op_div, ALU1_kill,
               ALU1_result_vld, ALU1_result_PR, ALU1_wakeup_vld, ALU1_wakeup_PR
    );

    modport slave (
        input  issue_vld, issue_is_div, issue_PR, flush, div_done, result_ack,
        output issue_rdy, ALU1_start, ALU1_op_div, ALU1_kill,
               ALU1_result_vld, ALU1_result_PR, ALU1_wakeup_vld, ALU1_wakeup_PR
    );
endinterface

// File: rtl/alu1_seq_ctrl.sv
// alu1_seq_ctrl
//   Sequencer for the shared ALU1 multiply/divide unit. It holds at most one op
//   in flight. A multiply completes a fixed MUL_LAT cycles after it is accepted.
//   A divide completes the cycle after div_done. The result is held in WB until
//   it is acknowledged. A flush cancels the op in flight from any state.
//
//   Parameter MUL_LAT : cycles from accept to first result_vld for a multiply (2..15).
//   Ports:
//     clk  : clock, all state on the rising edge
//     rst  : asynchronous active-high reset
//     bus  : alu1_seq_ctrl_if.slave. It carries the issue handshake, flush,
//            div_done, result_ack, the datapath start/kill, writeback and wakeup.
//
//   Optional feature: define ALU1_EARLY_WAKEUP_EN to broadcast a multiply's
//   wakeup in its last MUL cycle instead of in its first WB cycle.
//
//   state | meaning
//   IDLE  | nothing in flight, ready to accept
//   MUL   | multiply in flight, counting toward MUL_LAT
//   DIV   | divide in flight, waiting for div_done
//   WB    | result valid, waiting for result_ack
module alu1_seq_ctrl #(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic            clk,
    input  logic            rst,
    alu1_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_WB   = 2'd3
    } state_t;

    localparam logic [3:0] MUL_TC = 4'(MUL_LAT - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [5:0] pr_q, pr_d;
    logic       op_div_q, op_div_d;
    logic       first_wb_q, first_wb_d;

    logic       issue_rdy;
    logic       accept;
    logic       mul_tc;
    logic       result_vld;
    logic       wakeup_vld;

    // Ready is forced low while reset is held. A flush blocks any accept in
    // its own cycle.
    assign issue_rdy = ~rst & ~bus.flush &
                       ((state_q == S_IDLE) | ((state_q == S_WB) & bus.result_ack));
    assign accept    = bus.issue_vld & issue_rdy;
    assign mul_tc    = (state_q == S_MUL) && (cnt_q == MUL_TC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            pr_q       <= 6'd0;
            op_div_q   <= 1'b0;
            first_wb_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pr_q       <= pr_d;
            op_div_q   <= op_div_d;
            first_wb_q <= first_wb_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pr_d     = pr_q;
        op_div_d = op_div_q;

        case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_MUL: begin
                if (mul_tc) begin
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DIV: begin
                if (bus.div_done) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (bus.result_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new accept comes from IDLE or from an acknowledged WB (back-to-back).
        if (accept) begin
            state_d  = bus.issue_is_div ? S_DIV : S_MUL;
            cnt_d    = 4'd1;
            pr_d     = bus.issue_PR;
            op_div_d = bus.issue_is_div;
        end

        // Flush overrides everything, including div_done and result_ack.
        if (bus.flush) begin
            state_d = S_IDLE;
        end

        // This flag marks the first WB cycle of an op. The wakeup keys off it,
        // so a stalled WB does not repeat the broadcast.
        first_wb_d = (state_d == S_WB) && (state_q != S_WB);
    end

    assign result_vld = (state_q == S_WB);

`ifdef ALU1_EARLY_WAKEUP_EN
    // The multiply wakeup goes out one cycle ahead of writeback. A flush in that
    // cycle does not suppress it, because consumers squash on flush themselves.
    assign wakeup_vld = mul_tc | (first_wb_q & op_div_q);
`else
    assign wakeup_vld = first_wb_q;
`endif

    assign bus.issue_rdy       = issue_rdy;
    assign bus.ALU1_start      = accept;
    assign bus.ALU1_op_div     = bus.issue_is_div;
    assign bus.ALU1_kill       = bus.flush & (state_q == S_DIV);
    assign bus.ALU1_result_vld = result_vld;
    assign bus.ALU1_result_PR  = result_vld ? pr_q : 6'd0;
    assign bus.ALU1_wakeup_vld = wakeup_vld;
    assign bus.ALU1_wakeup_PR  = wakeup_vld ? pr_q : 6'd0;

endmodule

// File: tb/tb_alu1_seq_ctrl.sv
module tb_alu1_seq_ctrl;

    localparam int MUL_LAT = 3;
`ifdef ALU1_EARLY_WAKEUP_EN
    localparam int EARLY = 1;
`else
    localparam int EARLY = 0;
`endif

    typedef struct {
        int pr;
        int due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;
    logic prev_vld = 1'b0;
    int   cur_pr = 0;
    exp_t sb_q[$];
    exp_t wk_q[$];

    alu1_seq_ctrl_if bus ();

    alu1_seq_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic idle_inputs();
        bus.issue_vld    = 1'b0;
        bus.issue_is_div = 1'b0;
        bus.issue_PR     = 6'd0;
        bus.flush        = 1'b0;
        bus.div_done     = 1'b0;
        bus.result_ack   = 1'b1;
    endtask

    task automatic next_cyc();
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic push_exp(input int pr, input int res_due, input int wk_due);
        exp_t e;
        e.pr  = pr;
        e.due = res_due;
        sb_q.push_back(e);
        e.due = wk_due;
        wk_q.push_back(e);
    endtask

    // Offers an op in the current cycle and expects it to be accepted.
    task automatic issue_op(input logic is_div, input logic [5:0] pr);
        bus.issue_vld    = 1'b1;
        bus.issue_is_div = is_div;
        bus.issue_PR     = pr;
        #1;
        chk("accept_start", bus.ALU1_start, 1);
        chk("accept_op_div", bus.ALU1_op_div, is_div);
        if (!is_div) push_exp(pr, cyc + MUL_LAT, cyc + MUL_LAT - EARLY);
    endtask

    task automatic pulse_div_done(input int pr);
        bus.div_done = 1'b1;
        push_exp(pr, cyc + 1, cyc + 1);
    endtask

    // Basic multiply with result_ack held high.
    task automatic run_mul_basic(input logic [5:0] pr);
        next_cyc();
        issue_op(1'b0, pr);
        for (int i = 1; i < MUL_LAT; i++) begin
            next_cyc();
            #1 chk("mul_busy_rdy", bus.issue_rdy, 0);
        end
        next_cyc();
        #1 chk("mul_res_vld", bus.ALU1_result_vld, 1);
        next_cyc();
        #1 chk("mul_res_gone", bus.ALU1_result_vld, 0);
        chk("mul_idle_rdy", bus.issue_rdy, 1);
    endtask

    // Scoreboard: results and wakeups are popped and compared as they appear.
    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            if (bus.ALU1_result_vld) begin
                if (!prev_vld) begin
                    chk("res_expected", sb_q.size() > 0, 1);
                    if (sb_q.size() > 0) begin
                        chk("res_pr", bus.ALU1_result_PR, sb_q[0].pr);
                        chk("res_cycle", cyc, sb_q[0].due);
                        cur_pr <= sb_q[0].pr;
                        void'(sb_q.pop_front());
                    end
                end else begin
                    chk("res_pr_stable", bus.ALU1_result_PR, cur_pr);
                end
            end else begin
                chk("res_pr_zero", bus.ALU1_result_PR, 0);
            end
            if (bus.ALU1_wakeup_vld) begin
                chk("wk_expected", wk_q.size() > 0, 1);
                if (wk_q.size() > 0) begin
                    chk("wk_pr", bus.ALU1_wakeup_PR, wk_q[0].pr);
                    chk("wk_cycle", cyc, wk_q[0].due);
                    void'(wk_q.pop_front());
                end
            end else begin
                chk("wk_pr_zero", bus.ALU1_wakeup_PR, 0);
            end
        end
        prev_vld <= bus.ALU1_result_vld;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        repeat (2) @(negedge clk);
        bus.issue_vld = 1'b1;
        #1;
        chk("rst_rdy", bus.issue_rdy, 0);
        chk("rst_start", bus.ALU1_start, 0);
        chk("rst_kill", bus.ALU1_kill, 0);
        chk("rst_res_vld", bus.ALU1_result_vld, 0);
        chk("rst_res_pr", bus.ALU1_result_PR, 0);
        chk("rst_wk_vld", bus.ALU1_wakeup_vld, 0);
        chk("rst_wk_pr", bus.ALU1_wakeup_PR, 0);
        bus.issue_vld = 1'b0;
        rst = 1'b0;
        #1 chk("rdy_after_rst", bus.issue_rdy, 1);
        mon_en = 1'b1;

        // Multiply, PR=5.
        run_mul_basic(6'd5);

        // div_done outside DIV is ignored.
        next_cyc();
        bus.div_done = 1'b1;
        next_cyc();
        #1 chk("div_done_idle_ignored", bus.ALU1_result_vld, 0);

        // Divide PR=9, div_done 20 cycles after the accept.
        next_cyc();
        issue_op(1'b1, 6'd9);
        for (int i = 1; i <= 20; i++) begin
            next_cyc();
            if (i == 20) pulse_div_done(9);
            #1 chk("div_busy_rdy", bus.issue_rdy, 0);
        end
        next_cyc();
        #1 chk("div_res_vld", bus.ALU1_result_vld, 1);

        // Stall: multiply PR=7, result_ack low for cycles 3..6.
        next_cyc();
        issue_op(1'b0, 6'd7);
        repeat (2) next_cyc();
        for (int i = 3; i <= 6; i++) begin
            next_cyc();
            bus.result_ack = 1'b0;
            #1 chk("stall_vld", bus.ALU1_result_vld, 1);
            chk("stall_rdy", bus.issue_rdy, 0);
        end
        next_cyc();
        #1 chk("stall_ack_vld", bus.ALU1_result_vld, 1);
        chk("stall_ack_rdy", bus.issue_rdy, 1);
        next_cyc();
        #1 chk("stall_done", bus.ALU1_result_vld, 0);

        // Back-to-back: a divide accepted in the WB cycle of a multiply.
        next_cyc();
        issue_op(1'b0, 6'd3);
        repeat (2) next_cyc();
        next_cyc();
        #1 chk("b2b_wb_vld", bus.ALU1_result_vld, 1);
        issue_op(1'b1, 6'd12);
        next_cyc();
        #1 chk("b2b_div_vld", bus.ALU1_result_vld, 0);
        chk("b2b_div_rdy", bus.issue_rdy, 0);
        repeat (3) next_cyc();
        next_cyc();
        pulse_div_done(12);
        next_cyc();
        next_cyc();

        // Flush in DIV at cycle 10, with div_done and a new offer in that cycle.
        next_cyc();
        issue_op(1'b1, 6'd20);
        repeat (9) next_cyc();
        next_cyc();
        bus.flush     = 1'b1;
        bus.div_done  = 1'b1;
        bus.issue_vld = 1'b1;
        bus.issue_PR  = 6'd33;
        #1 chk("flush_div_kill", bus.ALU1_kill, 1);
        chk("flush_div_rdy", bus.issue_rdy, 0);
        chk("flush_div_start", bus.ALU1_start, 0);
        next_cyc();
        #1 chk("post_flush_vld", bus.ALU1_result_vld, 0);
        chk("post_flush_rdy", bus.issue_rdy, 1);
        chk("post_flush_kill", bus.ALU1_kill, 0);
        repeat (3) next_cyc();

        // Flush in WB together with result_ack and a new offer.
        next_cyc();
        issue_op(1'b0, 6'd44);
        repeat (2) next_cyc();
        next_cyc();
        bus.flush        = 1'b1;
        bus.issue_vld    = 1'b1;
        bus.issue_is_div = 1'b1;
        bus.issue_PR     = 6'd50;
        #1 chk("flush_wb_vld", bus.ALU1_result_vld, 1);
        chk("flush_wb_rdy", bus.issue_rdy, 0);
        chk("flush_wb_start", bus.ALU1_start, 0);
        chk("flush_wb_kill", bus.ALU1_kill, 0);
        next_cyc();
        #1 chk("post_flush_wb_vld", bus.ALU1_result_vld, 0);
        chk("post_flush_wb_rdy", bus.issue_rdy, 1);

        // Flush early in MUL: the op is dropped with no result or wakeup.
        next_cyc();
        issue_op(1'b0, 6'd45);
        void'(sb_q.pop_back());
        void'(wk_q.pop_back());
        next_cyc();
        bus.flush = 1'b1;
        #1 chk("flush_mul_kill", bus.ALU1_kill, 0);
        repeat (4) next_cyc();
        #1 chk("flush_mul_idle", bus.issue_rdy, 1);

        // Async reset mid-MUL, then the basic multiply again.
        next_cyc();
        issue_op(1'b0, 6'd46);
        void'(sb_q.pop_back());
        void'(wk_q.pop_back());
        next_cyc();
        #3;
        rst = 1'b1;
        bus.issue_vld = 1'b1;
        #1 chk("arst_rdy", bus.issue_rdy, 0);
        chk("arst_start", bus.ALU1_start, 0);
        chk("arst_res_vld", bus.ALU1_result_vld, 0);
        chk("arst_res_pr", bus.ALU1_result_PR, 0);
        chk("arst_wk_vld", bus.ALU1_wakeup_vld, 0);
        next_cyc();
        #1 chk("arst_hold_vld", bus.ALU1_result_vld, 0);
        rst = 1'b0;
        next_cyc();
        #1 chk("arst_release_rdy", bus.issue_rdy, 1);
        chk("arst_release_vld", bus.ALU1_result_vld, 0);
        run_mul_basic(6'd5);

        repeat (3) next_cyc();
        chk("sb_drained", sb_q.size(), 0);
        chk("wk_drained", wk_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu1_seq_ctrl.md
ALU1_SEQ_CTRL -- requirements
Module: alu1_seq_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3, meaning cycles from issue accept to first result_vld for a multiply (legal 2..15).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port issue_vld  input  1  select stage offers an ALU1 op.
REQ-005 SHALL have port issue_is_div  input  1  1 = divide, 0 = multiply.
REQ-006 SHALL have port issue_PR  input  6  destination physical register of offered op.
REQ-007 SHALL have port issue_rdy  output  1  op accepted this cycle when issue_vld & issue_rdy.
REQ-008 SHALL have port flush  input  1  pipeline flush, cancels in-flight op.
REQ-009 SHALL have port div_done  input  1  divider reports quotient ready (one-cycle pulse).
REQ-010 SHALL have port result_ack  input  1  writeback port consumed the result this cycle.
REQ-011 SHALL have port ALU1_start  output  1  one-cycle start pulse to mul/div datapath.
REQ-012 SHALL have port ALU1_op_div  output  1  op type qualifier valid with ALU1_start.
REQ-013 SHALL have port ALU1_kill  output  1  one-cycle abort pulse to divider.
REQ-014 SHALL have ports ALU1_result_vld  output  1  and ALU1_result_PR  output  6  writeback request and tag; feed the wakeup tag mux.
REQ-015 SHALL have ports ALU1_wakeup_vld  output  1  and ALU1_wakeup_PR  output  6  wakeup broadcast to issue queues.

Function
REQ-016 SHALL implement FSM states IDLE, MUL, DIV, WB; one op in flight at most.
REQ-017 SHALL drive issue_rdy = ~flush & (IDLE | (WB & result_ack)).
REQ-018 SHALL drive ALU1_start = issue_vld & issue_rdy combinationally, ALU1_op_div = issue_is_div; on accept latch issue_PR and go to MUL or DIV.
REQ-019 SHALL in MUL count cycles with a 4-bit counter loaded 1 on accept; enter WB when counter equals MUL_LAT-1, so ALU1_result_vld first asserts exactly MUL_LAT cycles after the accept cycle.
REQ-020 SHALL in DIV wait indefinitely for div_done; div_done in cycle D yields WB (result_vld) in cycle D+1; div_done outside DIV ignored.
REQ-021 SHALL in WB hold ALU1_result_vld=1 and stable PR until result_ack; result_ack without new accept -> IDLE; with accept -> MUL/DIV (back-to-back, no bubble).
REQ-022 SHALL force ALU1_result_PR and ALU1_wakeup_PR to 6'b0 whenever the matching valid is 0.
REQ-023 SHALL on flush in any state go to IDLE next cycle, deassert result_vld/wakeup_vld next cycle, accept nothing that cycle; ALU1_kill = flush & (state==DIV).
REQ-024 SHALL give flush priority over div_done and result_ack in the same cycle (flush & result_ack: ack honoured, no new accept, -> IDLE).
REQ-025 SHALL assert ALU1_wakeup_vld for exactly one cycle per completed op, never for flushed ops before the flush cycle's next edge.

Reset
REQ-026 SHALL on rst asynchronously set state IDLE, counter 0, latched PR 0; outputs: issue_rdy=1 after release (0 while rst high), ALU1_start=0, ALU1_kill=0, result_vld=0, result_PR=0, wakeup_vld=0, wakeup_PR=0.
REQ-027 SHALL on rst mid-operation discard the op with no wakeup or result emitted.

Configuration
REQ-028 SHALL, without ALU1_EARLY_WAKEUP_EN, assert ALU1_wakeup_vld in the first WB cycle of every op.
REQ-029 SHALL, with ALU1_EARLY_WAKEUP_EN defined, assert ALU1_wakeup_vld for multiplies in the last MUL cycle (one cycle before first result_vld) and for divides in the first WB cycle; a flush in that MUL cycle still lets the early wakeup out (consumers rely on flush to squash).

Verification
REQ-030 Multiply, MUL_LAT=3: accept PR=5 at cycle 0, result_ack held 1 -> result_vld/PR=5 at cycle 3 only, wakeup at 3 (cycle 2 with ALU1_EARLY_WAKEUP_EN).
REQ-031 Divide: accept PR=9 at 0, div_done at 20 -> result_vld, PR=9 at 21; issue_rdy=0 cycles 1..20.
REQ-032 Stall: multiply PR=7, result_ack low cycles 3..6, high at 7 -> result_vld 3..7, PR stable 7, single wakeup at 3.
REQ-033 Back-to-back: in WB with result_ack=1 and issue_vld (div, PR=12) -> ALU1_start same cycle, state DIV next cycle, no idle bubble.
REQ-034 Flush in DIV at cycle 10 with div_done same cycle -> ALU1_kill=1 at 10, IDLE at 11, no result_vld or wakeup ever for that op.
REQ-035 Async reset asserted mid-MUL -> all outputs 0 immediately, IDLE after release, next op behaves as REQ-030.
